// File: rtl/judge7_scorer.sv
// Seven-judge scorer: trims one max and one min of seven 4-bit scores, averages the rest
// with round-half-up, and drives a 2-digit multiplexed 7-segment display.
module judge7_scorer #(
   parameter int SCAN_DIV = 1000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] scorein,
   input  logic       submit,
   output logic [7:0] seg,
   output logic [1:0] sel
);

   localparam int CW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;

   // LOAD is the first cycle of the show phase, spent computing the result
   typedef enum logic [1:0] {COLLECT, LOAD, SHOW} state_t;

   state_t        state, state_nxt;
   logic [2:0]    count;
   logic [6:0]    sum;
   logic [3:0]    max_s, min_s;
   logic [3:0]    result;
   logic          sub_d;
   logic          armed;
   logic          accept;
   logic [6:0]    trimmed;
   logic [CW-1:0] scan_cnt;
   logic          wrap;
   logic [1:0]    sel_nxt;
   logic [7:0]    tens_code, ones_code;
   logic [3:0]    ones_digit;

   function automatic logic [3:0] div5_round(input logic [6:0] t);
      logic [6:0] tp;
      logic [3:0] q;
      tp = t + 7'd2;
      q  = 4'd0;
      for (int k = 1; k <= 15; k++) begin
         if (tp >= 7'(5 * k)) q = 4'(k);
      end
      return q;
   endfunction

   function automatic logic [7:0] seg_enc(input logic [3:0] d);
      case (d)
         4'd0:    return 8'h3F;
         4'd1:    return 8'h06;
         4'd2:    return 8'h5B;
         4'd3:    return 8'h4F;
         4'd4:    return 8'h66;
         4'd5:    return 8'h6D;
         4'd6:    return 8'h7D;
         4'd7:    return 8'h07;
         4'd8:    return 8'h7F;
         4'd9:    return 8'h6F;
         default: return 8'h00;
      endcase
   endfunction

   // armed blocks a strobe already high at reset release until it drops once
   assign accept  = submit & ~sub_d & armed;
   assign trimmed = sum - {3'b000, max_s} - {3'b000, min_s};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sub_d <= 1'b0;
         armed <= 1'b0;
      end else begin
         sub_d <= submit;
         armed <= armed | ~submit;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= COLLECT;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         COLLECT: if (accept && count == 3'd6) state_nxt = LOAD;
         LOAD:    state_nxt = SHOW;
         SHOW:    if (accept) state_nxt = COLLECT;
         default: state_nxt = COLLECT;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count  <= 3'd0;
         sum    <= 7'd0;
         max_s  <= 4'd0;
         min_s  <= 4'd15;
         result <= 4'd0;
      end else begin
         if (state == COLLECT && accept) begin
            sum   <= sum + {3'b000, scorein};
            count <= count + 3'd1;
            if (scorein > max_s) max_s <= scorein;
            if (scorein < min_s) min_s <= scorein;
         end else if (state == SHOW && accept) begin
            sum   <= {3'b000, scorein};
            max_s <= scorein;
            min_s <= scorein;
            count <= 3'd1;
         end
         if (state == LOAD) result <= div5_round(trimmed);
      end
   end

   always_comb begin
      tens_code  = 8'h40;
      ones_digit = {1'b0, count};
      if (state == SHOW) begin
         if (result >= 4'd10) begin
            tens_code  = 8'h06;
            ones_digit = result - 4'd10;
         end else begin
            tens_code  = 8'h3F;
            ones_digit = result;
         end
      end
      ones_code = seg_enc(ones_digit);
   end

   assign wrap    = (scan_cnt == CW'(SCAN_DIV - 1));
   assign sel_nxt = wrap ? {sel[0], sel[1]} : sel;

   // seg is encoded for the digit selected after this edge so both change together
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         scan_cnt <= '0;
         sel      <= 2'b01;
         seg      <= 8'h3F;
      end else begin
         scan_cnt <= wrap ? '0 : scan_cnt + 1'b1;
         sel      <= sel_nxt;
         seg      <= sel_nxt[1] ? tens_code : ones_code;
      end
   end

endmodule

// File: tb/tb_judge7_scorer.sv
// Scoreboard bench for judge7_scorer: stimulus queues expected display pairs,
// a monitor captures both scan phases and compares.
module tb_judge7_scorer;

   localparam int SD = 4;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [3:0] scorein = 4'd0;
   logic       submit = 1'b0;
   logic [7:0] seg;
   logic [1:0] sel;

   int checks = 0;
   int errors = 0;

   typedef struct {
      int         id;
      logic [7:0] tens;
      logic [7:0] ones;
   } exp_t;

   exp_t exp_q[$];

   judge7_scorer #(.SCAN_DIV(SD)) dut (
      .clk(clk), .rst(rst), .scorein(scorein), .submit(submit), .seg(seg), .sel(sel)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic give(input logic [3:0] v, input int hold);
      @(negedge clk);
      scorein = v;
      submit  = 1'b1;
      repeat (hold) @(negedge clk);
      submit  = 1'b0;
      scorein = 4'hA;
      @(negedge clk);
   endtask

   task automatic expect_disp(input int id, input logic [7:0] t, input logic [7:0] o);
      exp_t e;
      e.id = id; e.tens = t; e.ones = o;
      exp_q.push_back(e);
      for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(negedge clk);
   endtask

   task automatic round(input logic [3:0] a, b, c, d, e, f, g);
      give(a, 1); give(b, 1); give(c, 1); give(d, 1);
      give(e, 1); give(f, 1); give(g, 1);
   endtask

   // Monitor: captures tens and ones phases after the display settles
   initial begin
      exp_t   e;
      logic   got_t, got_o;
      logic [7:0] cap_t, cap_o;
      forever begin
         @(negedge clk);
         if (exp_q.size() != 0) begin
            e = exp_q[0];
            repeat (3) @(negedge clk);
            got_t = 1'b0; got_o = 1'b0; cap_t = 8'h00; cap_o = 8'h00;
            for (int i = 0; i < 40 && !(got_t && got_o); i++) begin
               @(negedge clk);
               if (sel == 2'b10) begin cap_t = seg; got_t = 1'b1; end
               if (sel == 2'b01) begin cap_o = seg; got_o = 1'b1; end
            end
            if (!(got_t && got_o)) begin
               checks++;
               errors++;
               $display("FAIL scan_timeout id=%0d: sel=%b never showed both digits", e.id, sel);
            end else begin
               chk($sformatf("tens id=%0d", e.id), cap_t, e.tens);
               chk($sformatf("ones id=%0d", e.id), cap_o, e.ones);
            end
            void'(exp_q.pop_front());
         end
      end
   end

   initial begin
      logic [1:0] s0;
      int n;
      #2 rst = 1'b1;
      #1;
      chk("reset_seg", seg, 8'h3F);
      chk("reset_sel", sel, 2'b01);
      @(negedge clk);
      rst = 1'b0;

      // scan period and tens-phase content
      s0 = sel;
      n = 0;
      while (sel == s0 && n < 50) begin @(negedge clk); n++; end
      chk("first_toggle_sel", sel, 2'b10);
      chk("collect_tens_dash", seg, 8'h40);
      s0 = sel;
      n = 0;
      while (sel == s0 && n < 50) begin @(negedge clk); n++; end
      chk("scan_period", n, SD);

      round(5, 9, 3, 12, 7, 8, 6);
      expect_disp(1, 8'h3F, 8'h07);

      round(15, 15, 15, 15, 15, 15, 15);
      expect_disp(2, 8'h06, 8'h6D);

      give(2, 1);
      expect_disp(3, 8'h40, 8'h06);
      give(2, 1); give(3, 1); give(3, 1); give(3, 1); give(0, 1); give(9, 1);
      expect_disp(4, 8'h3F, 8'h4F);

      round(10, 10, 10, 10, 11, 1, 15);
      expect_disp(5, 8'h06, 8'h3F);

      give(4, 50);
      expect_disp(6, 8'h40, 8'h06);
      give(4, 50);
      expect_disp(7, 8'h40, 8'h5B);
      give(1, 3);
      expect_disp(8, 8'h40, 8'h4F);

      // mid-round reset, with submit held high across the release
      @(negedge clk);
      #2 rst = 1'b1;
      #1;
      chk("midreset_seg", seg, 8'h3F);
      chk("midreset_sel", sel, 2'b01);
      submit = 1'b1;
      scorein = 4'd9;
      @(negedge clk);
      rst = 1'b0;
      repeat (5) @(negedge clk);
      submit = 1'b0;
      @(negedge clk);
      expect_disp(9, 8'h40, 8'h3F);

      round(1, 2, 3, 4, 5, 6, 7);
      expect_disp(10, 8'h3F, 8'h66);

      give(6, 1);
      expect_disp(11, 8'h40, 8'h06);

      repeat (5) @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
